// File: rtl/commit_trace_buffer.sv
// Captures retiring-instruction commit records into a FIFO and drains each as a 3-beat 32-bit stream.
// Latency: first beat visible the cycle after push; full FIFO drops new records (counted) unless a pop frees a slot.
module commit_trace_buffer #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_retire,
    input  logic                     i_capture_en,
    input  logic                     i_wb_only,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_inst,
    input  logic [31:0]              i_writeBack,
    input  logic                     i_RegWEn,
    input  logic                     i_memRW,
    input  logic                     i_clear,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_data,
    output logic [1:0]               o_beat,
    output logic                     o_last,
    output logic [1:0]               o_flags,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [DROP_W-1:0]        o_drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {BEAT0 = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2} state_t;

    typedef struct packed {
        logic        mem_rw;
        logic        reg_wen;
        logic [31:0] wb;
        logic [31:0] inst;
        logic [31:0] pc;
    } rec_t;

    rec_t              mem_q [DEPTH];
    rec_t              mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic push_req, pop, push_ok, drop, valid, full;
    rec_t head;

    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == FULL_CNT);
        push_req = i_retire & i_capture_en & (~i_wb_only | i_RegWEn | i_memRW);
        pop      = valid & i_ready & (state_q == BEAT2);
        // A pop in the same cycle frees the slot the incoming record needs.
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{mem_rw: i_memRW, reg_wen: i_RegWEn, wb: i_writeBack,
                                inst: i_inst, pc: i_pc};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);

        state_d = state_q;
        if (valid & i_ready) begin
            case (state_q)
                BEAT0:   state_d = BEAT1;
                BEAT1:   state_d = BEAT2;
                default: state_d = BEAT0;
            endcase
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (i_clear) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (i_clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= BEAT0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload is gated so an empty buffer presents zeros rather than stale entries.
    always_comb begin
        head   = mem_q[rd_ptr_q];
        o_data = '0;
        if (valid) begin
            case (state_q)
                BEAT0:   o_data = head.pc;
                BEAT1:   o_data = head.inst;
                default: o_data = head.wb;
            endcase
        end
        o_flags      = valid ? {head.mem_rw, head.reg_wen} : 2'b00;
        o_valid      = valid;
        o_beat       = state_q;
        o_last       = (state_q == BEAT2);
        o_count      = count_q;
        o_overflow   = overflow_q;
        o_drop_count = drop_cnt_q;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: vector table plus hand sequences for backpressure, overflow, clear and reset.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_retire, i_capture_en, i_wb_only, i_RegWEn, i_memRW, i_clear, i_ready;
    logic [31:0] i_pc, i_inst, i_writeBack;
    logic        o_valid, o_last, o_overflow;
    logic [31:0] o_data;
    logic [1:0]  o_beat, o_flags;
    logic [3:0]  o_count;
    logic [15:0] o_drop_count;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(8), .DROP_W(16)) dut (
        .clk(clk), .reset(reset),
        .i_retire(i_retire), .i_capture_en(i_capture_en), .i_wb_only(i_wb_only),
        .i_pc(i_pc), .i_inst(i_inst), .i_writeBack(i_writeBack),
        .i_RegWEn(i_RegWEn), .i_memRW(i_memRW), .i_clear(i_clear),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_beat(o_beat),
        .o_last(o_last), .o_flags(o_flags), .o_count(o_count),
        .o_overflow(o_overflow), .o_drop_count(o_drop_count)
    );

    typedef struct {
        logic        retire, cap, wbo;
        logic [31:0] pc, inst, wb;
        logic        rw, mw, rdy;
        logic        valid;
        logic [31:0] data;
        logic [1:0]  beat;
        logic        last;
        logic [1:0]  flags;
        logic [3:0]  count;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, cap, wbo, input logic [31:0] pc, inst, wb,
                                input logic rw, mw, rdy, v, input logic [31:0] d,
                                input logic [1:0] b, input logic l, input logic [1:0] f,
                                input logic [3:0] c);
        vec_t t;
        t.retire = r; t.cap = cap; t.wbo = wbo; t.pc = pc; t.inst = inst; t.wb = wb;
        t.rw = rw; t.mw = mw; t.rdy = rdy; t.valid = v; t.data = d; t.beat = b;
        t.last = l; t.flags = f; t.count = c;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive(input logic r, cap, wbo, input logic [31:0] pc, inst, wb,
                         input logic rw, mw, rdy);
        i_retire = r; i_capture_en = cap; i_wb_only = wbo; i_pc = pc; i_inst = inst;
        i_writeBack = wb; i_RegWEn = rw; i_memRW = mw; i_ready = rdy; i_clear = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b0);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_count", {28'b0, o_count}, 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_beat_last", {29'b0, o_beat, o_last}, 32'h0);
        chk("rst_ovf_drop", {15'b0, o_overflow, o_drop_count}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single record, then wb_only filter (sw, branch, addi), then capture disabled.
        tbl.push_back(mk(1,1,0, 32'h4, 32'h00500513, 32'h5, 1,0,1,  1, 32'h4,        2'd0,0,2'b01,4'd1));
        tbl.push_back(mk(0,1,0, 32'h0, 32'h0, 32'h0,        0,0,1,  1, 32'h00500513, 2'd1,0,2'b01,4'd1));
        tbl.push_back(mk(0,1,0, 32'h0, 32'h0, 32'h0,        0,0,1,  1, 32'h5,        2'd2,1,2'b01,4'd1));
        tbl.push_back(mk(0,1,0, 32'h0, 32'h0, 32'h0,        0,0,1,  0, 32'h0,        2'd0,0,2'b00,4'd0));
        tbl.push_back(mk(1,1,1, 32'h10, 32'h00a12023, 32'h1000, 0,1,1, 1, 32'h10,   2'd0,0,2'b10,4'd1));
        tbl.push_back(mk(1,1,1, 32'h14, 32'h00b50463, 32'h0,    0,0,1, 1, 32'h00a12023, 2'd1,0,2'b10,4'd1));
        tbl.push_back(mk(1,1,1, 32'h18, 32'h00150513, 32'h6,    1,0,1, 1, 32'h1000, 2'd2,1,2'b10,4'd2));
        tbl.push_back(mk(0,1,1, 32'h0, 32'h0, 32'h0,        0,0,1,  1, 32'h18,       2'd0,0,2'b01,4'd1));
        tbl.push_back(mk(0,1,1, 32'h0, 32'h0, 32'h0,        0,0,1,  1, 32'h00150513, 2'd1,0,2'b01,4'd1));
        tbl.push_back(mk(0,1,1, 32'h0, 32'h0, 32'h0,        0,0,1,  1, 32'h6,        2'd2,1,2'b01,4'd1));
        tbl.push_back(mk(0,1,1, 32'h0, 32'h0, 32'h0,        0,0,1,  0, 32'h0,        2'd0,0,2'b00,4'd0));
        tbl.push_back(mk(1,0,0, 32'h50, 32'h13, 32'h0,      1,0,1,  0, 32'h0,        2'd0,0,2'b00,4'd0));

        foreach (tbl[i]) begin
            drive(tbl[i].retire, tbl[i].cap, tbl[i].wbo, tbl[i].pc, tbl[i].inst, tbl[i].wb,
                  tbl[i].rw, tbl[i].mw, tbl[i].rdy);
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].valid});
            chk($sformatf("v%0d_data", i), o_data, tbl[i].data);
            chk($sformatf("v%0d_beat", i), {30'b0, o_beat}, {30'b0, tbl[i].beat});
            chk($sformatf("v%0d_last", i), {31'b0, o_last}, {31'b0, tbl[i].last});
            chk($sformatf("v%0d_flags", i), {30'b0, o_flags}, {30'b0, tbl[i].flags});
            chk($sformatf("v%0d_count", i), {28'b0, o_count}, {28'b0, tbl[i].count});
        end

        // Backpressure held on beat 1.
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h00500513, 32'h5, 1'b1, 1'b0, 1'b0);
        step();
        idle(1'b1);
        step();
        chk("bp_beat1", {30'b0, o_beat}, 32'd1);
        idle(1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_hold_data%0d", k), o_data, 32'h00500513);
            chk($sformatf("bp_hold_beat%0d", k), {30'b0, o_beat}, 32'd1);
        end
        idle(1'b1);
        step();
        chk("bp_beat2_data", o_data, 32'h5);
        chk("bp_beat2_last", {31'b0, o_last}, 32'd1);
        step();
        chk("bp_popped", {28'b0, o_count}, 32'd0);

        // Overflow: 12 retires into 8 slots with the sink stalled.
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h13, 32'(k), 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("ovf_count", {28'b0, o_count}, 32'd8);
        chk("ovf_flag", {31'b0, o_overflow}, 32'd1);
        chk("ovf_drops", {16'b0, o_drop_count}, 32'd4);

        // Full with beat 2 accepted alongside a new retire: no drop.
        idle(1'b1);
        chk("full_head_pc", o_data, 32'h100);
        step();
        step();
        chk("full_at_beat2", {30'b0, o_beat}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        chk("fpp_count", {28'b0, o_count}, 32'd8);
        chk("fpp_drops", {16'b0, o_drop_count}, 32'd4);
        chk("fpp_beat0", {30'b0, o_beat}, 32'd0);
        idle(1'b1);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_pc%0d", k), o_data, (k < 8) ? 32'h100 + 32'(4 * k) : 32'h200);
            repeat (3) step();
        end
        chk("drain_empty", {28'b0, o_count}, 32'd0);

        // Drop and clear in the same cycle: the drop wins.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h13, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h13, 32'h0, 1'b1, 1'b0, 1'b0);
        i_clear = 1'b1;
        step();
        chk("clr_drop_ovf", {31'b0, o_overflow}, 32'd1);
        chk("clr_drop_cnt", {16'b0, o_drop_count}, 32'd1);
        idle(1'b0);
        i_clear = 1'b1;
        step();
        chk("clr_ovf", {31'b0, o_overflow}, 32'd0);
        chk("clr_cnt", {16'b0, o_drop_count}, 32'd0);

        // Async reset in the middle of a record.
        idle(1'b1);
        step();
        chk("mid_beat1", {30'b0, o_beat}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, o_valid}, 32'd0);
        chk("ar_count", {28'b0, o_count}, 32'd0);
        chk("ar_beat", {30'b0, o_beat}, 32'd0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h13, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ar_new_valid", {31'b0, o_valid}, 32'd1);
        chk("ar_new_beat", {30'b0, o_beat}, 32'd0);
        chk("ar_new_pc", o_data, 32'h300);
        chk("ar_new_count", {28'b0, o_count}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream consumer of the KLP32V1 core's per-cycle debug outputs (PC, instruction, writeback, RegWEn, memRW).
- Captures one commit record per retiring cycle into a FIFO.
- Drains each record as a 3-beat, 32-bit valid/ready stream for a UART/host trace port.
- Decouples single-cycle retirement rate from a slower trace sink, with drop accounting on overflow.

Parameters:
- DEPTH, 8, FIFO depth in records. Power of two, ≥2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_retire  input  1  core retired an instruction this cycle
- i_capture_en  input  1  global capture enable; 0 suppresses all pushes
- i_wb_only  input  1  1 = capture only records with RegWEn or memRW set
- i_pc  input  32  retiring PC (core o_pcOut)
- i_inst  input  32  retiring instruction (core o_inst)
- i_writeBack  input  32  writeback value (core o_writeBack)
- i_RegWEn  input  1  register write enable (core o_RegWEn)
- i_memRW  input  1  memory write (core o_memRW)
- i_clear  input  1  synchronous clear of o_overflow and o_drop_count
- o_valid  output  1  output beat valid
- i_ready  input  1  sink accepts beat
- o_data  output  32  beat payload
- o_beat  output  2  beat index: 0 = PC, 1 = INST, 2 = WB
- o_last  output  1  high on beat 2
- o_flags  output  2  {memRW, RegWEn} of head record, valid on all beats
- o_count  output  $clog2(DEPTH)+1  records held, including the one draining
- o_overflow  output  1  sticky: at least one record dropped
- o_drop_count  output  DROP_W  saturating count of dropped records

Behaviour:
- Reset values: all outputs 0; FIFO empty; pointers, beat counter, overflow and drop count cleared.
- Reset asserted mid-transfer aborts the record; no partial beats after reset deasserts.
- Push request: i_retire & i_capture_en & (~i_wb_only | i_RegWEn | i_memRW).
- Record width is 98 bits: {memRW, RegWEn, writeBack, inst, pc}, sampled on the clk edge of the push.
- Pop occurs on (o_valid & i_ready & o_beat==2).
- Push is accepted if count<DEPTH, or if a pop occurs in the same cycle (full + pop + push keeps count=DEPTH).
- Empty + push + no pop: count increments by 1.
- Dropped push (full, no pop):
  - record discarded;
  - o_overflow set;
  - o_drop_count increments, saturating at all-ones.
- i_clear, when high, clears o_overflow and o_drop_count the next edge. A drop in the same cycle as i_clear wins: overflow=1, drop_count=1.
- Latency: a record pushed at edge N into an empty FIFO shows o_valid=1, o_beat=0 after edge N; no combinational input-to-output path.
- Output FSM states are BEAT0, BEAT1 and BEAT2; o_valid = (count!=0).
  - State advances only on o_valid & i_ready.
  - BEAT2 → BEAT0 on pop.
  - The state holds while i_ready=0; o_data, o_beat and o_flags stay stable while o_valid & ~i_ready.
- o_data mux by state: BEAT0 = pc, BEAT1 = inst, BEAT2 = writeBack. o_last = (state==BEAT2).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count tracks occupancy independently.
- Back-to-back records: after a pop with count>1, the next record's BEAT0 is presented the following cycle with no bubble.
- Maximum sustained drain is 1 record per 3 cycles. At full retire rate the FIFO fills and drops are expected and counted.

Test Plan:
- Single record: push pc=0x4, inst=0x00500513, wb=5, RegWEn=1, memRW=0, i_ready=1 → beats 0x4/0x00500513/0x5, o_beat 0,1,2, o_last on beat 2, o_flags=2'b01; count returns to 0.
- Backpressure: hold i_ready=0 for 5 cycles on beat 1 → o_data stays 0x00500513, no advance; release → beat 2, then pop.
- Filter: i_wb_only=1; retire sw (memRW=1, RegWEn=0), then a branch (both 0), then addi → exactly 2 records emitted; the branch is never seen.
- Overflow, DEPTH=8: 12 consecutive retires with i_ready=0 → count=8, o_overflow=1, o_drop_count=4; the drained PCs are the first 8 pushed, in order.
- Full + simultaneous pop/push: FIFO full, beat 2 accepted in the same cycle as a retire → no drop, count stays 8, the new record is drained last.
- Async reset mid-record (during beat 1) → o_valid=0 and count=0 immediately; after release, the next push starts at beat 0. Also i_clear → o_drop_count=0, o_overflow=0.
